top_irq_aggregator: RTL and testbench

//  Collects interrupt lines from the interval timers and other peripherals (timer irq, MIPI/frame

---
 rtl/top_irq_aggregator.sv | 92 +++++++++
 tb/tb_top_irq_aggregator.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/top_irq_aggregator.sv
// top_irq_aggregator: synchronise, qualify, latch and mask interrupt sources into one CPU irq
module top_irq_aggregator #(
  parameter int          NUM_SRC     = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] EDGE_RESET  = 16'h00FF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               irq
);
  logic [NUM_SRC-1:0] chain [SYNC_STAGES];
  logic [NUM_SRC-1:0] sync, sync_d, rise, pending, mask, edge_mode, w1c, masked;
  logic [SYNC_STAGES:0] warm;
  logic [15:0] count, rd_mux, active;
  logic wr, irq_nxt, inc, unused_ok;
  assign wr        = chipselect & ~write_n;
  assign sync      = chain[SYNC_STAGES-1];
  // warm holds off edge detection until sync_d has caught up after reset, so a source
  // held high across reset release is not mistaken for a new edge
  assign rise      = sync & ~sync_d & {NUM_SRC{warm[SYNC_STAGES]}};
  assign w1c       = (wr && address == 3'd1) ? writedata[NUM_SRC-1:0] : '0;
  assign masked    = pending & mask;
  assign irq_nxt   = |masked;
  assign inc       = irq_nxt & ~irq;
  assign unused_ok = &{1'b0, writedata};
  // source synchroniser, edge-detect delay and post-reset warm-up
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= '0;
      sync_d <= '0;
      warm   <= '0;
    end else begin
      chain[0] <= irq_src;
      for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
      sync_d <= sync;
      warm   <= {warm[SYNC_STAGES-1:0], 1'b1};
    end
  end
  // pending: edge mode sets on rise (wins over W1C), level mode follows sync
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= (edge_mode & (rise | (pending & ~w1c))) | (~edge_mode & sync);
  end
  // MASK and EDGE configuration registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask      <= '0;
      edge_mode <= EDGE_RESET[NUM_SRC-1:0];
    end else if (wr && address == 3'd2) mask <= writedata[NUM_SRC-1:0];
    else if (wr && address == 3'd3) edge_mode <= writedata[NUM_SRC-1:0];
  end
  // saturating irq-rise counter; a clear coinciding with a rise keeps that rise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count <= '0;
    else if (wr && address == 3'd5) count <= {15'b0, inc};
    else if (inc && count != 16'hFFFF) count <= count + 16'd1;
  end
  // lowest-index pending-and-enabled source wins
  always_comb begin
    active = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) if (masked[i]) active = {1'b1, 11'b0, 4'(i)};
  end
  // register read mux
  always_comb begin
    rd_mux = '0;
    case (address)
      3'd0:    rd_mux = 16'(sync);
      3'd1:    rd_mux = 16'(pending);
      3'd2:    rd_mux = 16'(mask);
      3'd3:    rd_mux = 16'(edge_mode);
      3'd4:    rd_mux = active;
      3'd5:    rd_mux = count;
      default: rd_mux = '0;
    endcase
  end
  // registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq      <= 1'b0;
      readdata <= '0;
    end else begin
      irq      <= irq_nxt;
      readdata <= rd_mux;
    end
  end
endmodule

// File: tb/tb_top_irq_aggregator.sv
// tb_top_irq_aggregator: table-driven register checks plus timed irq sequences
module tb_top_irq_aggregator;
  logic clk = 0, reset = 1, chipselect = 0, write_n = 1, irq, rd_req = 0;
  logic [2:0]  address = '0;
  logic [15:0] writedata = '0, readdata;
  logic [7:0]  irq_src = '0;
  int n_chk = 0, n_fail = 0;
  typedef struct { string n; logic [15:0] exp; } sb_t;
  sb_t sb[$];
  typedef struct { logic w; logic [2:0] a; logic [15:0] d; logic [15:0] exp; string n; } vec_t;
  vec_t vecs[13];
  top_irq_aggregator dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata), .irq_src(irq_src), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic check(input string n, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  // read monitor: readdata is valid just after the edge that sampled the address
  always @(posedge clk) begin
    if (rd_req) begin
      sb_t e;
      #1;
      if (sb.size() == 0) check("sb_underflow", 16'd1, 16'd0);
      else begin
        e = sb.pop_front();
        check(e.n, readdata, e.exp);
      end
    end
  end
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    address = a; writedata = d; chipselect = 1; write_n = 0;
    @(negedge clk);
    chipselect = 0; write_n = 1;
  endtask
  task automatic rd(input logic [2:0] a, input logic [15:0] e, input string n);
    address = a; chipselect = 1; write_n = 1; rd_req = 1;
    sb.push_back('{n, e});
    @(negedge clk);
    chipselect = 0; rd_req = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    vecs = '{
      '{0, 3'd2, 16'h0000, 16'h0000, "rst_mask"},
      '{0, 3'd3, 16'h0000, 16'h00FF, "rst_edge"},
      '{0, 3'd1, 16'h0000, 16'h0000, "rst_pending"},
      '{0, 3'd4, 16'h0000, 16'h0000, "rst_active"},
      '{0, 3'd5, 16'h0000, 16'h0000, "rst_count"},
      '{1, 3'd2, 16'hFFFF, 16'h0000, ""},
      '{0, 3'd2, 16'h0000, 16'h00FF, "mask_upper_ignored"},
      '{1, 3'd3, 16'h1234, 16'h0000, ""},
      '{0, 3'd3, 16'h0000, 16'h0034, "edge_rw"},
      '{1, 3'd6, 16'hFFFF, 16'h0000, ""},
      '{0, 3'd6, 16'h0000, 16'h0000, "addr6_zero"},
      '{1, 3'd3, 16'h00FF, 16'h0000, ""},
      '{1, 3'd2, 16'h0000, 16'h0000, ""}
    };
    step(2);
    check("rst_irq", 16'(irq), 16'h0);
    check("rst_readdata", readdata, 16'h0);
    reset = 0;
    step(1);
    foreach (vecs[i]) begin
      if (vecs[i].w) wr(vecs[i].a, vecs[i].d);
      else rd(vecs[i].a, vecs[i].exp, vecs[i].n);
    end
    rd(3'd7, 16'h0, "addr7_zero");
    rd(3'd2, 16'h0, "mask_cleared");
    // 1: edge source, 4-edge latency, W1C, count
    wr(3'd2, 16'h0001);
    irq_src = 8'h01; step(1); irq_src = 8'h00; step(2);
    check("t1_irq_early", 16'(irq), 16'h0);
    step(1);
    check("t1_irq_lat4", 16'(irq), 16'h1);
    rd(3'd1, 16'h0001, "t1_pending");
    wr(3'd1, 16'h0001);
    step(1);
    check("t1_irq_clr", 16'(irq), 16'h0);
    rd(3'd5, 16'h0001, "t1_count");
    // 2: lowest index first
    wr(3'd2, 16'h000C);
    irq_src = 8'h08; step(4);
    irq_src = 8'h0C; step(4);
    rd(3'd4, 16'h8002, "t2_active2");
    wr(3'd1, 16'h0004);
    rd(3'd4, 16'h8003, "t2_active3");
    wr(3'd1, 16'h0008);
    rd(3'd4, 16'h0000, "t2_active_none");
    irq_src = 8'h00; step(3);
    // 3: level source
    wr(3'd3, 16'h0000); wr(3'd2, 16'h0002);
    irq_src = 8'h02; step(3);
    check("t3_irq_early", 16'(irq), 16'h0);
    step(1);
    check("t3_irq_lat", 16'(irq), 16'h1);
    wr(3'd1, 16'h0002); step(1);
    check("t3_w1c_noeffect", 16'(irq), 16'h1);
    rd(3'd1, 16'h0002, "t3_pending");
    irq_src = 8'h00; step(3);
    check("t3_drop_early", 16'(irq), 16'h1);
    step(1);
    check("t3_drop_lat", 16'(irq), 16'h0);
    rd(3'd1, 16'h0000, "t3_pending_clr");
    // 4: W1C in the same cycle as a new rise
    wr(3'd3, 16'h00FF); wr(3'd2, 16'h0001);
    irq_src = 8'h01; step(1); irq_src = 8'h00; step(3);
    check("t4_irq_set", 16'(irq), 16'h1);
    irq_src = 8'h01; step(1); irq_src = 8'h00; step(1);
    wr(3'd1, 16'h0001);
    check("t4_irq_hold", 16'(irq), 16'h1);
    rd(3'd1, 16'h0001, "t4_pending_kept");
    step(1);
    check("t4_irq_hold2", 16'(irq), 16'h1);
    wr(3'd1, 16'h0001); step(2);
    check("t4_irq_clr", 16'(irq), 16'h0);
    // 5: count saturation and clear
    wr(3'd3, 16'h0000); wr(3'd2, 16'h0000);
    irq_src = 8'h01; step(3);
    force dut.count = 16'hFFFD;
    step(1);
    release dut.count;
    rd(3'd5, 16'hFFFD, "t5_preload");
    repeat (3) begin
      wr(3'd2, 16'h0001); wr(3'd2, 16'h0000);
    end
    rd(3'd5, 16'hFFFF, "t5_saturate");
    wr(3'd5, 16'h0000);
    rd(3'd5, 16'h0000, "t5_clear");
    wr(3'd2, 16'h0001); wr(3'd5, 16'h0000);
    rd(3'd5, 16'h0001, "t5_clear_with_rise");
    // 6: asynchronous reset mid-operation
    wr(3'd2, 16'h00FF);
    check("t6_irq_pre", 16'(irq), 16'h1);
    rd(3'd2, 16'h00FF, "t6_mask_pre");
    irq_src = 8'hFF;
    #2 reset = 1;
    #1;
    check("t6_async_irq", 16'(irq), 16'h0);
    check("t6_async_readdata", readdata, 16'h0);
    @(negedge clk); reset = 0;
    step(5);
    rd(3'd3, 16'h00FF, "t6_edge");
    rd(3'd2, 16'h0000, "t6_mask");
    rd(3'd1, 16'h0000, "t6_no_pending");
    rd(3'd0, 16'h00FF, "t6_status");
    rd(3'd5, 16'h0000, "t6_count");
    check("t6_irq_post", 16'(irq), 16'h0);
    irq_src = 8'h00;
    step(2);
    check("sb_drain", 16'(sb.size()), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
